// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC blocks: angle format, gain constant,
// range limit, arctan(2^-i) table in Q8.32 degrees and FSM state encoding.
package cordic_pkg;

  localparam int ANGLE_W = 40;
  localparam int FRAC_W  = 32;
  localparam int ATAN_N  = 38;

  typedef logic signed [ANGLE_W-1:0] angle_t;

  // Pre-scaled start vector length so the rotation gain comes out at 1.0
  localparam angle_t CORDIC_K = 40'sh00_9B74EDA8;

  // Largest legal magnitude of the requested angle
  localparam angle_t DEG90 = 40'sh5A_00000000;

  // arctan(2^-i) in degrees, Q8.32, rounded to nearest
  localparam angle_t ATAN_TABLE [0:ATAN_N-1] = '{
    40'sd193273528320, 40'sd114096026022, 40'sd60285206653,  40'sd30601712202,
    40'sd15360239180,  40'sd7687607525,   40'sd3844741810,   40'sd1922488225,
    40'sd961258780,    40'sd480631223,    40'sd240315841,    40'sd120157949,
    40'sd60078978,     40'sd30039489,     40'sd15019745,     40'sd7509872,
    40'sd3754936,      40'sd1877468,      40'sd938734,       40'sd469367,
    40'sd234684,       40'sd117342,       40'sd58671,        40'sd29335,
    40'sd14668,        40'sd7334,         40'sd3667,         40'sd1833,
    40'sd917,          40'sd458,          40'sd229,          40'sd115,
    40'sd57,           40'sd29,           40'sd14,           40'sd7,
    40'sd4,            40'sd2
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctan(2^-i) lookup; indices past the table return zero.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [5:0] idx,
  output angle_t     atan
);

  // Table lookup with a safe zero for unused indices
  always_comb begin
    atan = '0;
    if (idx < 6'(ATAN_N)) begin
      atan = ATAN_TABLE[idx];
    end
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: angle in Q8.32 degrees -> cos/sin in Q2.30,
// one micro-rotation per clock behind a start/busy/done handshake.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int ITER = 32,
  parameter int OW   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [ANGLE_W-1:0] angle_in,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic signed [OW-1:0]      cos_out,
  output logic signed [OW-1:0]      sin_out
);

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_t     state;
  state_t     state_next;
  angle_t     x;
  angle_t     y;
  angle_t     z;
  angle_t     atan_i;
  angle_t     x_shift;
  angle_t     y_shift;
  logic [5:0] iter;
  logic       range_err;

  cordic_atan_rom u_rom (
    .idx  (iter),
    .atan (atan_i)
  );

  assign x_shift = x >>> iter;
  assign y_shift = y >>> iter;
  assign busy    = (state == RUN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: accept start only when idle, run ITER rotations, one result cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (iter == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rotation datapath: load on acceptance, rotate toward z = 0 while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      range_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x         <= CORDIC_K;
            y         <= '0;
            z         <= angle_in;
            iter      <= '0;
            range_err <= (angle_in > DEG90) || (angle_in < -DEG90);
          end
        end
        RUN: begin
          if (!z[ANGLE_W-1]) begin
            x <= x - y_shift;
            y <= y + x_shift;
            z <= z - atan_i;
          end else begin
            x <= x + y_shift;
            y <= y - x_shift;
            z <= z + atan_i;
          end
          iter <= iter + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: publish once per operation and hold until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      err     <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        err     <= range_err;
        cos_out <= range_err ? '0 : x[FRAC_W+1 -: OW];
        sin_out <= range_err ? '0 : y[FRAC_W+1 -: OW];
      end
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: table of angles with hand-computed
// cos/sin, plus sequences for ignored start, mid-run reset and back-to-back use.
module tb_cordic_sincos;

  localparam int ITER     = 32;
  localparam int OW       = 32;
  localparam int TOL      = 4;
  localparam int MAX_WAIT = 100;
  localparam int NV       = 12;

  typedef struct {
    logic signed [39:0] angle;
    longint             expCos;
    longint             expSin;
    logic               expErr;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic signed [39:0]   angle_in;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic signed [OW-1:0] cos_out;
  logic signed [OW-1:0] sin_out;

  int errors = 0;
  int checks = 0;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  cordic_sincos #(.ITER(ITER), .OW(OW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .angle_in (angle_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cos_out  (cos_out),
    .sin_out  (sin_out)
  );

  function automatic longint absDiff(input longint a, input longint b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // One comparison with tolerance; every call counts as a check
  task automatic checkOutput(input string name, input longint actual, input longint expected, input longint tol);
    checks++;
    if (absDiff(actual, expected) > tol) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d (+/-%0d)", name, actual, expected, tol);
    end
  endtask

  // Launch one operation and wait (bounded) for its done pulse; returns at the done cycle
  task automatic applyStimulus(input logic signed [39:0] ang, output int lat, output int busyCnt, output int both);
    @(negedge clk);
    angle_in = ang;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    lat     = 0;
    busyCnt = 0;
    both    = 0;
    while (!done && lat < MAX_WAIT) begin
      if (busy) busyCnt++;
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (busy && done) both++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: no done within %0d cycles", MAX_WAIT);
    end
  endtask

  initial begin
    int lat, bcnt, both, nd, de, cnt, cyc, unstable;
    longint capCos, capSin, capErr;
    int doneCyc [3];
    logic signed [39:0] bbAng [3];
    longint bbCos [3];
    longint bbSin [3];

    vecs[0]  = '{40'sh00_00000000,  1073741824,           0, 1'b0};
    vecs[1]  = '{40'sh1E_00000000,   929887697,   536870912, 1'b0};
    vecs[2]  = '{-40'sh2D_00000000,  759250125,  -759250125, 1'b0};
    vecs[3]  = '{40'sh5A_00000000,           0,  1073741824, 1'b0};
    vecs[4]  = '{-40'sh5A_00000000,          0, -1073741824, 1'b0};
    vecs[5]  = '{40'sh3C_00000000,   536870912,   929887697, 1'b0};
    vecs[6]  = '{40'sh2D_00000000,   759250125,   759250125, 1'b0};
    vecs[7]  = '{-40'sh1E_00000000,  929887697,  -536870912, 1'b0};
    vecs[8]  = '{40'sh5A_00000001,           0,           0, 1'b1};
    vecs[9]  = '{40'sh64_00000000,           0,           0, 1'b1};
    vecs[10] = '{-40'sh64_00000000,          0,           0, 1'b1};
    vecs[11] = '{-40'sh5A_00000001,          0,           0, 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    angle_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0, 0);
    checkOutput("reset done", done, 0, 0);
    checkOutput("reset err", err, 0, 0);
    checkOutput("reset cos", cos_out, 0, 0);
    checkOutput("reset sin", sin_out, 0, 0);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      applyStimulus(vecs[v].angle, lat, bcnt, both);
      checkOutput($sformatf("v%0d latency", v), lat, ITER + 1, 0);
      checkOutput($sformatf("v%0d busy cycles", v), bcnt, ITER, 0);
      checkOutput($sformatf("v%0d busy with done", v), both, 0, 0);
      checkOutput($sformatf("v%0d cos", v), cos_out, vecs[v].expCos, vecs[v].expErr ? 0 : TOL);
      checkOutput($sformatf("v%0d sin", v), sin_out, vecs[v].expSin, vecs[v].expErr ? 0 : TOL);
      checkOutput($sformatf("v%0d err", v), err, vecs[v].expErr, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("v%0d done width", v), done, 0, 0);
    end

    // start pulsed twice during RUN with another angle must be ignored
    @(negedge clk);
    angle_in = 40'sh1E_00000000;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    angle_in = 40'sh3C_00000000;
    nd = 0; de = -1; capCos = 0; capSin = 0; capErr = 1;
    for (int k = 1; k <= 80; k++) begin
      start = (k == 6 || k == 21);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) begin
          de = k; capCos = cos_out; capSin = sin_out; capErr = err;
        end
      end
    end
    start = 1'b0;
    checkOutput("ignore: done count", nd, 1, 0);
    checkOutput("ignore: done edge", de, ITER + 1, 0);
    checkOutput("ignore: cos", capCos, 929887697, TOL);
    checkOutput("ignore: sin", capSin, 536870912, TOL);
    checkOutput("ignore: err", capErr, 0, 0);

    // reset in the middle of RUN aborts the operation asynchronously
    @(negedge clk);
    angle_in = 40'sh2D_00000000;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("abort: busy before reset", busy, 1, 0);
    rst = 1'b1;
    #1;
    checkOutput("abort: busy", busy, 0, 0);
    checkOutput("abort: done", done, 0, 0);
    checkOutput("abort: err", err, 0, 0);
    checkOutput("abort: cos", cos_out, 0, 0);
    checkOutput("abort: sin", sin_out, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) cnt++;
    end
    checkOutput("abort: activity after reset", cnt, 0, 0);
    applyStimulus(-40'sh1E_00000000, lat, bcnt, both);
    checkOutput("abort: fresh latency", lat, ITER + 1, 0);
    checkOutput("abort: fresh cos", cos_out, 929887697, TOL);
    checkOutput("abort: fresh sin", sin_out, -536870912, TOL);

    // start held high across three operations
    bbAng[0] = 40'sh3C_00000000;  bbCos[0] = 536870912; bbSin[0] = 929887697;
    bbAng[1] = -40'sh2D_00000000; bbCos[1] = 759250125; bbSin[1] = -759250125;
    bbAng[2] = 40'sh00_00000000;  bbCos[2] = 1073741824; bbSin[2] = 0;
    doneCyc[0] = 0; doneCyc[1] = 0; doneCyc[2] = 0;
    @(posedge clk);
    @(negedge clk);
    angle_in = bbAng[0];
    start    = 1'b1;
    nd = 0; cyc = 0; unstable = 0; both = 0;
    while (nd < 3 && cyc < 150) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (busy && done) both++;
      if (done) begin
        doneCyc[nd] = cyc;
        checkOutput($sformatf("b2b op%0d cos", nd), cos_out, bbCos[nd], TOL);
        checkOutput($sformatf("b2b op%0d sin", nd), sin_out, bbSin[nd], TOL);
        nd++;
        if (nd < 3) angle_in = bbAng[nd];
        else start = 1'b0;
      end else if (nd > 0) begin
        if (absDiff(cos_out, bbCos[nd-1]) > TOL || absDiff(sin_out, bbSin[nd-1]) > TOL) unstable++;
      end
    end
    start = 1'b0;
    checkOutput("b2b done count", nd, 3, 0);
    checkOutput("b2b first done", doneCyc[0], ITER + 2, 0);
    checkOutput("b2b spacing 1", doneCyc[1] - doneCyc[0], ITER + 2, 0);
    checkOutput("b2b spacing 2", doneCyc[2] - doneCyc[1], ITER + 2, 0);
    checkOutput("b2b held outputs", unstable, 0, 0);
    checkOutput("b2b busy with done", both, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
